video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Pixel-domain raster timing source that drives the position counters, sync strobes and display-enable consumed by the sprite renderers and the HDMI TMDS path.
- Generates signed horizontal/vertical positions: active picture is 0..ACTIVE-1; blanking (front porch, sync, back porch, in that order) occupies the negative range.
- A consumer can therefore pre-fetch by comparing against negative coordinates ahead of column/row 0.
- Defaults give 720x480p60 at the 27 MHz pixel clock.

Parameters:
- H_ACTIVE, 720, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 62, horizontal sync width (pixels)
- H_BP, 60, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 30, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 0, 1 inverts hSyncPin/vSyncPin only; logical hSync/vSync are unaffected

Ports:
- pixelClock  in  1  pixel clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  1 = raster advances; 0 = all state and outputs hold
- hPos  out  11 signed  horizontal position, -(H_FP+H_SYNC+H_BP) .. H_ACTIVE-1
- vPos  out  10 signed  vertical position, -(V_FP+V_SYNC+V_BP) .. V_ACTIVE-1
- hSync  out  1  logical high during the horizontal sync interval
- vSync  out  1  logical high during vertical sync lines
- hSyncPin  out  1  hSync XOR SYNC_ACTIVE_LOW
- vSyncPin  out  1  vSync XOR SYNC_ACTIVE_LOW
- displayEnable  out  1  high when hPos>=0 and vPos>=0
- lineStart  out  1  one-cycle pulse when hPos = -H_BLANK
- frameStart  out  1  one-cycle pulse when hPos = -H_BLANK and vPos = -V_BLANK

Behaviour:
- Definitions: H_BLANK = H_FP+H_SYNC+H_BP (138); V_BLANK = V_FP+V_SYNC+V_BP (45).
- Total pixels per line = H_BLANK+H_ACTIVE (858); total lines per frame = V_BLANK+V_ACTIVE (525).
- Reset (reset_n=0 at a pixelClock edge):
  - hPos=-H_BLANK, vPos=-V_BLANK.
  - hSync=0, vSync=0, displayEnable=0, lineStart=0, frameStart=0.
  - hSyncPin=vSyncPin=SYNC_ACTIVE_LOW.
  - Reset overrides enable. Reset mid-frame restarts the raster with no partial-line completion.
- Counting, each cycle with enable=1:
  - hPos increments by 1.
  - At hPos=H_ACTIVE-1, hPos wraps to -H_BLANK and vPos increments.
  - At vPos=V_ACTIVE-1 with the horizontal wrap, vPos wraps to -V_BLANK.
  - vPos changes only on the horizontal wrap.
- Output registration and alignment:
  - All outputs are registered and decoded from the next-state counter values.
  - Every strobe is therefore coincident with the hPos/vPos it describes, with zero skew between counters and strobes.
- hSync: high when -H_BLANK+H_FP <= hPos <= -H_BLANK+H_FP+H_SYNC-1, i.e. -122..-61 by default.
- vSync: high for every pixel of lines with -V_BLANK+V_FP <= vPos <= -V_BLANK+V_FP+V_SYNC-1, i.e. -36..-31. It is line-aligned and asserts/deasserts together with the horizontal wrap.
- displayEnable: high only when both counters are >= 0.
- lineStart and frameStart pulse for exactly the cycle their condition holds. They do not repeat while enable=0 holds that state.
- enable=0: counters and every output, including pulses, freeze at their current values. The raster resumes from the same point when enable returns to 1.
- Width rules:
  - Comparisons are signed; do not rely on unsigned wrap.
  - Elaboration error if H_BLANK+H_ACTIVE > 1024+H_ACTIVE, V_BLANK > 512, H_ACTIVE > 1023 or V_ACTIVE > 511.
- There are no other states: the design is two chained counters plus registered decode, with no FSM beyond wrap control.

Test Plan:
- Release reset with enable=1 -> first cycle shows hPos=-138, vPos=-45, lineStart=1, frameStart=1, displayEnable=0. After 858 cycles hPos returns to -138 and vPos=-44.
- Count cycles between frameStart pulses -> exactly 450450 (858x525). Between lineStart pulses -> 858. displayEnable high for 345600 cycles per frame.
- Sample hSync across a line -> rises when hPos=-122, falls when hPos=-60, width 62 cycles. With SYNC_ACTIVE_LOW=1, hSyncPin is the exact inverse.
- Sample vSync across a frame -> rises with the wrap into vPos=-36, falls with the wrap into vPos=-30, high for 6x858=5148 cycles.
- Drop enable for 10 cycles at hPos=719, vPos=479 -> outputs frozen with displayEnable=1. When enable returns: next hPos=-138, vPos=-45, frameStart=1 for one cycle only.
- Assert reset_n=0 for 1 cycle at hPos=300, vPos=200 -> next cycle hPos=-138, vPos=-45, all strobes at reset values, normal counting resumes.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing source: chained signed pixel/line counters with registered sync, enable and
// start strobes decoded from the next-state counter values so strobes never skew from positions.
module video_timing_gen #(
   parameter int H_ACTIVE        = 720,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 62,
   parameter int H_BP            = 60,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 9,
   parameter int V_SYNC          = 6,
   parameter int V_BP            = 30,
   parameter bit SYNC_ACTIVE_LOW = 1'b0
) (
   input  logic               pixelClock,
   input  logic               reset_n,
   input  logic               enable,
   output logic signed [10:0] hPos,
   output logic signed [9:0]  vPos,
   output logic               hSync,
   output logic               vSync,
   output logic               hSyncPin,
   output logic               vSyncPin,
   output logic               displayEnable,
   output logic               lineStart,
   output logic               frameStart
);

   localparam int H_BLANK = H_FP + H_SYNC + H_BP;
   localparam int V_BLANK = V_FP + V_SYNC + V_BP;

   if (H_BLANK > 1024 || V_BLANK > 512 || H_ACTIVE > 1023 || V_ACTIVE > 511) begin : g_bad_params
      $error("video_timing_gen: raster does not fit the signed position counters");
   end

   localparam logic signed [10:0] H_FIRST    = 11'(-H_BLANK);
   localparam logic signed [10:0] H_LAST     = 11'(H_ACTIVE - 1);
   localparam logic signed [10:0] HS_START   = 11'(H_FP - H_BLANK);
   localparam logic signed [10:0] HS_END     = 11'(H_FP + H_SYNC - 1 - H_BLANK);
   localparam logic signed [9:0]  V_FIRST    = 10'(-V_BLANK);
   localparam logic signed [9:0]  V_LAST     = 10'(V_ACTIVE - 1);
   localparam logic signed [9:0]  VS_START   = 10'(V_FP - V_BLANK);
   localparam logic signed [9:0]  VS_END     = 10'(V_FP + V_SYNC - 1 - V_BLANK);

   logic signed [10:0] h_q, h_d;
   logic signed [9:0]  v_q, v_d;
   logic               primed_q, primed_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               hsync_pin_q, hsync_pin_d;
   logic               vsync_pin_q, vsync_pin_d;
   logic               de_q, de_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   // The first enabled cycle after reset presents the start position with its strobes
   // instead of advancing, so a frame always begins with lineStart/frameStart.
   always_comb begin
      h_d      = h_q;
      v_d      = v_q;
      primed_d = primed_q;
      if (enable) begin
         primed_d = 1'b1;
         if (primed_q) begin
            if (h_q == H_LAST) begin
               h_d = H_FIRST;
               v_d = (v_q == V_LAST) ? V_FIRST : v_q + 10'sd1;
            end else begin
               h_d = h_q + 11'sd1;
            end
         end
      end
   end

   always_comb begin
      hsync_d       = (h_d >= HS_START) && (h_d <= HS_END);
      vsync_d       = (v_d >= VS_START) && (v_d <= VS_END);
      hsync_pin_d   = hsync_d ^ SYNC_ACTIVE_LOW;
      vsync_pin_d   = vsync_d ^ SYNC_ACTIVE_LOW;
      de_d          = (h_d >= 11'sd0) && (v_d >= 10'sd0);
      line_start_d  = (h_d == H_FIRST);
      frame_start_d = (h_d == H_FIRST) && (v_d == V_FIRST);
   end

   always_ff @(posedge pixelClock) begin
      if (!reset_n) begin
         h_q           <= H_FIRST;
         v_q           <= V_FIRST;
         primed_q      <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         hsync_pin_q   <= SYNC_ACTIVE_LOW;
         vsync_pin_q   <= SYNC_ACTIVE_LOW;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (enable) begin
         h_q           <= h_d;
         v_q           <= v_d;
         primed_q      <= primed_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hsync_pin_q   <= hsync_pin_d;
         vsync_pin_q   <= vsync_pin_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hPos          = h_q;
   assign vPos          = v_q;
   assign hSync         = hsync_q;
   assign vSync         = vsync_q;
   assign hSyncPin      = hsync_pin_q;
   assign vSyncPin      = vsync_pin_q;
   assign displayEnable = de_q;
   assign lineStart     = line_start_q;
   assign frameStart    = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 720x480 instance and a small active-low-sync instance
// share clock, reset and enable, and are compared against an arithmetic raster model.
module tb_video_timing_gen;

   localparam int SHA = 20, SHF = 3, SHS = 4, SHB = 5;
   localparam int SVA = 10, SVF = 2, SVS = 3, SVB = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;

   logic signed [10:0] d_hpos, s_hpos;
   logic signed [9:0]  d_vpos, s_vpos;
   logic d_hs, d_vs, d_hsp, d_vsp, d_de, d_ls, d_fs;
   logic s_hs, s_vs, s_hsp, s_vsp, s_de, s_ls, s_fs;
   logic [27:0] d_vec, s_vec;

   int checks = 0;
   int failures = 0;

   // Model state: number of advances since the first enabled cycle after reset.
   int m_k = 0;
   bit m_st = 1'b0;

   always #5 clk = ~clk;

   video_timing_gen dut_d (
      .pixelClock(clk), .reset_n(reset_n), .enable(enable),
      .hPos(d_hpos), .vPos(d_vpos), .hSync(d_hs), .vSync(d_vs),
      .hSyncPin(d_hsp), .vSyncPin(d_vsp), .displayEnable(d_de),
      .lineStart(d_ls), .frameStart(d_fs)
   );

   video_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .SYNC_ACTIVE_LOW(1'b1)
   ) dut_s (
      .pixelClock(clk), .reset_n(reset_n), .enable(enable),
      .hPos(s_hpos), .vPos(s_vpos), .hSync(s_hs), .vSync(s_vs),
      .hSyncPin(s_hsp), .vSyncPin(s_vsp), .displayEnable(s_de),
      .lineStart(s_ls), .frameStart(s_fs)
   );

   assign d_vec = {d_hpos, d_vpos, d_hs, d_vs, d_hsp, d_vsp, d_de, d_ls, d_fs};
   assign s_vec = {s_hpos, s_vpos, s_hs, s_vs, s_hsp, s_vsp, s_de, s_ls, s_fs};

   always @(posedge clk) begin
      if (!reset_n) begin
         m_st <= 1'b0;
         m_k  <= 0;
      end else if (enable) begin
         if (m_st) m_k <= m_k + 1;
         else      m_st <= 1'b1;
      end
   end

   function automatic logic [27:0] model_vec(input int k, input bit st,
                                             input int ha, input int hf, input int hs, input int hb,
                                             input int va, input int vf, input int vs, input int vb,
                                             input bit sal);
      int hbl, vbl, col, line, eh, ev;
      bit ehs, evs, ede, els, efs;
      hbl = hf + hs + hb;
      vbl = vf + vs + vb;
      if (!st) begin
         eh = -hbl; ev = -vbl;
         ehs = 0; evs = 0; ede = 0; els = 0; efs = 0;
      end else begin
         col  = k % (hbl + ha);
         line = (k / (hbl + ha)) % (vbl + va);
         eh   = col - hbl;
         ev   = line - vbl;
         ehs  = (col >= hf) && (col < hf + hs);
         evs  = (line >= vf) && (line < vf + vs);
         ede  = (eh >= 0) && (ev >= 0);
         els  = (col == 0);
         efs  = (col == 0) && (line == 0);
      end
      return {11'(eh), 10'(ev), ehs, evs, ehs ^ sal, evs ^ sal, ede, els, efs};
   endfunction

   task automatic step(input bit en);
      enable = en;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      step(1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)));
      checks++;
      if (d_hpos !== -138) begin
         failures++; $display("FAIL reset_hpos: got %0d expected -138", d_hpos);
      end
      checks++;
      if (d_vpos !== -45) begin
         failures++; $display("FAIL reset_vpos: got %0d expected -45", d_vpos);
      end
      checks++;
      if ({d_hs, d_vs, d_de, d_ls, d_fs} !== 5'b0) begin
         failures++;
         $display("FAIL reset_strobes: got %b expected 00000", {d_hs, d_vs, d_de, d_ls, d_fs});
      end
      checks++;
      if ({d_hsp, d_vsp} !== 2'b00) begin
         failures++; $display("FAIL reset_pins_hi: got %b expected 00", {d_hsp, d_vsp});
      end
      checks++;
      if ({s_hpos, s_vpos} !== {-11'sd12, -10'sd9}) begin
         failures++; $display("FAIL reset_small_pos: got %0d,%0d expected -12,-9", s_hpos, s_vpos);
      end
      checks++;
      if ({s_hsp, s_vsp, s_ls, s_fs} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_pins_lo: got %b expected 1100", {s_hsp, s_vsp, s_ls, s_fs});
      end
   endtask

   task automatic test_first_line;
      int rise, fall, width, inv_bad;
      bit prev;
      rise = 9999; fall = 9999; width = 0; inv_bad = 0;
      reset_n = 1'b1;
      step(1'b1);
      checks++;
      if ({d_hpos, d_vpos} !== {-11'sd138, -10'sd45}) begin
         failures++; $display("FAIL first_pos: got %0d,%0d expected -138,-45", d_hpos, d_vpos);
      end
      checks++;
      if ({d_ls, d_fs, d_de} !== 3'b110) begin
         failures++; $display("FAIL first_strobes: got %b expected 110", {d_ls, d_fs, d_de});
      end
      prev = d_hs;
      for (int i = 0; i < 858; i++) begin
         step(1'b1);
         if (d_hs && !prev) rise = d_hpos;
         if (!d_hs && prev) fall = d_hpos;
         if (d_hs) width++;
         prev = d_hs;
         if (s_hsp !== ~s_hs) inv_bad++;
      end
      checks++;
      if ({d_hpos, d_vpos, d_ls, d_fs} !== {-11'sd138, -10'sd44, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL line_wrap: got %0d,%0d ls=%b fs=%b expected -138,-44 ls=1 fs=0",
                  d_hpos, d_vpos, d_ls, d_fs);
      end
      checks++;
      if (rise !== -122 || fall !== -60) begin
         failures++; $display("FAIL hsync_edges: got %0d,%0d expected -122,-60", rise, fall);
      end
      checks++;
      if (width !== 62) begin
         failures++; $display("FAIL hsync_width: got %0d expected 62", width);
      end
      checks++;
      if (inv_bad !== 0) begin
         failures++; $display("FAIL hsync_pin_inverse: got %0d bad cycles expected 0", inv_bad);
      end
   endtask

   task automatic test_frame_small;
      int n, lines, de, vsc, hsc, inv_bad, vrise_v, vrise_h, vfall_v;
      bit found, prev;
      n = 0; lines = 0; de = 0; vsc = 0; hsc = 0; inv_bad = 0;
      vrise_v = 999; vrise_h = 999; vfall_v = 999;
      found = 1'b0;
      for (int i = 0; i < 1300; i++) begin
         step(1'b1);
         if (s_fs) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
         failures++; $display("FAIL frame_wait: got no frameStart expected one within 1300");
      end
      prev = s_vs;
      for (int i = 0; i < 2000; i++) begin
         if (s_ls) lines++;
         if (s_de) de++;
         if (s_vs) vsc++;
         if (s_hs) hsc++;
         if (s_vs && !prev) begin vrise_v = s_vpos; vrise_h = s_hpos; end
         if (!s_vs && prev) vfall_v = s_vpos;
         prev = s_vs;
         if (s_hsp !== ~s_hs || s_vsp !== ~s_vs) inv_bad++;
         step(1'b1);
         n++;
         if (s_fs) break;
      end
      checks++;
      if (n !== 608) begin
         failures++; $display("FAIL frame_period: got %0d expected 608", n);
      end
      checks++;
      if (lines !== 19) begin
         failures++; $display("FAIL line_count: got %0d expected 19", lines);
      end
      checks++;
      if (de !== 200) begin
         failures++; $display("FAIL de_count: got %0d expected 200", de);
      end
      checks++;
      if (vsc !== 96 || hsc !== 76) begin
         failures++; $display("FAIL sync_counts: got v=%0d h=%0d expected v=96 h=76", vsc, hsc);
      end
      checks++;
      if (vrise_v !== -7 || vrise_h !== -12 || vfall_v !== -4) begin
         failures++;
         $display("FAIL vsync_edges: got rise %0d@%0d fall %0d expected rise -7@-12 fall -4",
                  vrise_v, vrise_h, vfall_v);
      end
      checks++;
      if (inv_bad !== 0) begin
         failures++; $display("FAIL pin_inverse: got %0d bad cycles expected 0", inv_bad);
      end
   endtask

   task automatic test_freeze;
      bit found;
      int bad;
      found = 1'b0; bad = 0;
      for (int i = 0; i < 700; i++) begin
         step(1'b1);
         if (s_hpos == 19 && s_vpos == 9) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
         failures++; $display("FAIL freeze_wait: got no 19,9 position expected one within 700");
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         if ({s_hpos, s_vpos, s_de, s_ls, s_fs} !== {11'sd19, 10'sd9, 1'b1, 1'b0, 1'b0}) bad++;
         if (d_vec !== model_vec(m_k, m_st, 720, 16, 62, 60, 480, 9, 6, 30, 1'b0)) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++; $display("FAIL freeze_hold: got %0d bad samples expected 0", bad);
      end
      step(1'b1);
      checks++;
      if ({s_hpos, s_vpos, s_fs, s_ls, s_de} !== {-11'sd12, -10'sd9, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL freeze_resume: got %0d,%0d fs=%b expected -12,-9 fs=1", s_hpos, s_vpos, s_fs);
      end
      step(1'b1);
      checks++;
      if ({s_hpos, s_fs} !== {-11'sd11, 1'b0}) begin
         failures++; $display("FAIL frame_pulse_once: got %0d fs=%b expected -11 fs=0", s_hpos, s_fs);
      end
   endtask

   task automatic test_midframe_reset;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 700; i++) begin
         step(1'b1);
         if (s_hpos == 10 && s_vpos == 5) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
         failures++; $display("FAIL midreset_wait: got no 10,5 position expected one within 700");
      end
      reset_n = 1'b0;
      step(1'b1);
      reset_n = 1'b1;
      checks++;
      if ({s_hpos, s_vpos, s_hs, s_vs, s_de, s_ls, s_fs, s_hsp, s_vsp} !==
          {-11'sd12, -10'sd9, 7'b0000011}) begin
         failures++;
         $display("FAIL midreset_state: got %0d,%0d %b expected -12,-9 0000011", s_hpos, s_vpos,
                  {s_hs, s_vs, s_de, s_ls, s_fs, s_hsp, s_vsp});
      end
      checks++;
      if ({d_hpos, d_vpos, d_ls} !== {-11'sd138, -10'sd45, 1'b0}) begin
         failures++; $display("FAIL midreset_big: got %0d,%0d expected -138,-45", d_hpos, d_vpos);
      end
      step(1'b1);
      checks++;
      if ({s_hpos, s_vpos, s_ls, s_fs} !== {-11'sd12, -10'sd9, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL midreset_restart: got %0d,%0d ls=%b fs=%b expected -12,-9 1 1",
                  s_hpos, s_vpos, s_ls, s_fs);
      end
      step(1'b1);
      checks++;
      if ({s_hpos, s_ls} !== {-11'sd11, 1'b0}) begin
         failures++; $display("FAIL midreset_count: got %0d ls=%b expected -11 0", s_hpos, s_ls);
      end
   endtask

   task automatic test_random_enable;
      logic [27:0] exp_d, exp_s;
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 499) != 0);
         step($urandom_range(0, 3) != 0);
         exp_d = model_vec(m_k, m_st, 720, 16, 62, 60, 480, 9, 6, 30, 1'b0);
         exp_s = model_vec(m_k, m_st, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1);
         checks++;
         if (d_vec !== exp_d) begin
            failures++; $display("FAIL random_big: cycle %0d got %h expected %h", i, d_vec, exp_d);
         end
         checks++;
         if (s_vec !== exp_s) begin
            failures++; $display("FAIL random_small: cycle %0d got %h expected %h", i, s_vec, exp_s);
         end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_frame_small();
      test_freeze();
      test_midframe_reset();
      test_random_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
